// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between two SRAM clients, the port arbiter and the spi_sram_encoder.
// The arbiter uses the slave view; the clients and encoder together use the master view.
interface sram_port_arbiter_if #(
  parameter int unsigned WORD_WIDTH    = 16,
  parameter int unsigned ADDRESS_WIDTH = 16
) ();

  logic                     a_req;
  logic [ADDRESS_WIDTH-1:0] a_address;
  logic                     a_write_enable;
  logic [WORD_WIDTH-1:0]    a_data_out;
  logic                     a_ack;
  logic [WORD_WIDTH-1:0]    a_data_in;

  logic                     b_req;
  logic [ADDRESS_WIDTH-1:0] b_address;
  logic                     b_write_enable;
  logic [WORD_WIDTH-1:0]    b_data_out;
  logic                     b_ack;
  logic [WORD_WIDTH-1:0]    b_data_in;

  logic                     enc_request;
  logic [ADDRESS_WIDTH-1:0] enc_address;
  logic                     enc_write_enable;
  logic [WORD_WIDTH-1:0]    enc_data_out;
  logic [WORD_WIDTH-1:0]    enc_data_in;
  logic                     enc_busy;
  logic                     enc_initialized;

  modport slave (
    input  a_req, a_address, a_write_enable, a_data_out,
    output a_ack, a_data_in,
    input  b_req, b_address, b_write_enable, b_data_out,
    output b_ack, b_data_in,
    output enc_request, enc_address, enc_write_enable, enc_data_out,
    input  enc_data_in, enc_busy, enc_initialized
  );

  modport master (
    output a_req, a_address, a_write_enable, a_data_out,
    input  a_ack, a_data_in,
    output b_req, b_address, b_write_enable, b_data_out,
    input  b_ack, b_data_in,
    input  enc_request, enc_address, enc_write_enable, enc_data_out,
    output enc_data_in, enc_busy, enc_initialized
  );

endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin two-port front end for spi_sram_encoder: converts req/ack clients into
// the encoder's request/busy handshake and latches the returned word per port.
module sram_port_arbiter #(
  parameter int unsigned WORD_WIDTH    = 16,
  parameter int unsigned ADDRESS_WIDTH = 16
) (
  input logic                  clk,
  input logic                  reset,
  sram_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;
  typedef enum logic {PortA, PortB} port_e;

  state_e                   state_q, state_d;
  port_e                    grant_q, grant_d;
  port_e                    last_grant_q, last_grant_d;
  logic                     enc_request_q, enc_request_d;
  logic [ADDRESS_WIDTH-1:0] enc_address_q, enc_address_d;
  logic                     enc_write_enable_q, enc_write_enable_d;
  logic [WORD_WIDTH-1:0]    enc_data_out_q, enc_data_out_d;
  logic                     a_ack_q, a_ack_d;
  logic                     b_ack_q, b_ack_d;
  logic [WORD_WIDTH-1:0]    a_data_in_q, a_data_in_d;
  logic [WORD_WIDTH-1:0]    b_data_in_q, b_data_in_d;

  logic  can_grant;
  port_e winner;

  assign can_grant = bus.enc_initialized && !bus.enc_busy && (bus.a_req || bus.b_req);
  // On contention the port that did not win last time goes next.
  assign winner = (bus.b_req && (!bus.a_req || last_grant_q == PortA)) ? PortB : PortA;

  always_comb begin
    state_d            = state_q;
    grant_d            = grant_q;
    last_grant_d       = last_grant_q;
    enc_request_d      = enc_request_q;
    enc_address_d      = enc_address_q;
    enc_write_enable_d = enc_write_enable_q;
    enc_data_out_d     = enc_data_out_q;
    a_ack_d            = 1'b0;
    b_ack_d            = 1'b0;
    a_data_in_d        = a_data_in_q;
    b_data_in_d        = b_data_in_q;

    unique case (state_q)
      StIdle: begin
        if (can_grant) begin
          grant_d       = winner;
          last_grant_d  = winner;
          enc_request_d = 1'b1;
          state_d       = StIssue;
          if (winner == PortB) begin
            enc_address_d      = bus.b_address;
            enc_write_enable_d = bus.b_write_enable;
            enc_data_out_d     = bus.b_data_out;
          end else begin
            enc_address_d      = bus.a_address;
            enc_write_enable_d = bus.a_write_enable;
            enc_data_out_d     = bus.a_data_out;
          end
        end
      end
      StIssue: begin
        if (bus.enc_busy) begin
          enc_request_d = 1'b0;
          state_d       = StWait;
        end
      end
      StWait: begin
        // Writes also capture enc_data_in: the encoder echoes the written word.
        if (!bus.enc_busy) begin
          state_d = StAck;
          if (grant_q == PortB) begin
            b_data_in_d = bus.enc_data_in;
            b_ack_d     = 1'b1;
          end else begin
            a_data_in_d = bus.enc_data_in;
            a_ack_d     = 1'b1;
          end
        end
      end
      StAck: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= StIdle;
      grant_q            <= PortA;
      last_grant_q       <= PortB;
      enc_request_q      <= 1'b0;
      enc_address_q      <= '0;
      enc_write_enable_q <= 1'b0;
      enc_data_out_q     <= '0;
      a_ack_q            <= 1'b0;
      b_ack_q            <= 1'b0;
      a_data_in_q        <= '0;
      b_data_in_q        <= '0;
    end else begin
      state_q            <= state_d;
      grant_q            <= grant_d;
      last_grant_q       <= last_grant_d;
      enc_request_q      <= enc_request_d;
      enc_address_q      <= enc_address_d;
      enc_write_enable_q <= enc_write_enable_d;
      enc_data_out_q     <= enc_data_out_d;
      a_ack_q            <= a_ack_d;
      b_ack_q            <= b_ack_d;
      a_data_in_q        <= a_data_in_d;
      b_data_in_q        <= b_data_in_d;
    end
  end

  assign bus.enc_request      = enc_request_q;
  assign bus.enc_address      = enc_address_q;
  assign bus.enc_write_enable = enc_write_enable_q;
  assign bus.enc_data_out     = enc_data_out_q;
  assign bus.a_ack            = a_ack_q;
  assign bus.b_ack            = b_ack_q;
  assign bus.a_data_in        = a_data_in_q;
  assign bus.b_data_in        = b_data_in_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter with a behavioural encoder stub
// (busy 2 cycles after request, 12 cycles long; reads return 0xBEEF, writes echo).
module tb_sram_port_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sram_port_arbiter_if bus ();

  sram_port_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_ack_cyc = -100;
  int overlap  = 0;
  int max_overlap = 0;
  int ack_total = 0;
  logic prev_req = 1'b0;
  logic [16:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Encoder stub
  logic [1:0]  stub_st;
  logic [1:0]  stub_dly;
  logic [3:0]  stub_cnt;
  logic [15:0] stub_word;

  always @(posedge clk) begin
    if (reset) begin
      stub_st         <= 2'd0;
      stub_dly        <= 2'd0;
      stub_cnt        <= 4'd0;
      stub_word       <= 16'h0;
      bus.enc_busy    <= 1'b0;
      bus.enc_data_in <= 16'h0;
    end else begin
      case (stub_st)
        2'd0: if (bus.enc_request) begin
          stub_st   <= 2'd1;
          stub_dly  <= 2'd1;
          stub_word <= bus.enc_write_enable ? bus.enc_data_out : 16'hBEEF;
        end
        2'd1: if (stub_dly == 2'd0) begin
          bus.enc_busy <= 1'b1;
          stub_cnt     <= 4'd11;
          stub_st      <= 2'd2;
        end else begin
          stub_dly <= stub_dly - 2'd1;
        end
        default: begin
          bus.enc_data_in <= stub_word;
          if (stub_cnt == 4'd0) begin
            bus.enc_busy <= 1'b0;
            stub_st      <= 2'd0;
          end else begin
            stub_cnt <= stub_cnt - 4'd1;
          end
        end
      endcase
    end
  end

  // Monitor: pops the scoreboard on every ack and watches handshake spacing.
  always @(negedge clk) begin
    logic [16:0] e;
    cyc++;
    if (bus.a_ack && bus.b_ack) check("acks_together", 1, 0);
    if (bus.a_ack || bus.b_ack) begin
      ack_total++;
      last_ack_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_ack", {30'd0, bus.b_ack, bus.a_ack}, 0);
      end else begin
        e = exp_q.pop_front();
        check("ack_port", {31'd0, bus.b_ack}, {31'd0, e[16]});
        check("ack_data", {16'd0, (bus.b_ack ? bus.b_data_in : bus.a_data_in)},
              {16'd0, e[15:0]});
      end
    end
    if (bus.enc_request && !prev_req && last_ack_cyc > 0)
      check("idle_gap_ge2", {31'd0, (cyc - last_ack_cyc) >= 2}, 1);
    prev_req = bus.enc_request;
    if (bus.enc_request && bus.enc_busy) overlap++;
    else overlap = 0;
    if (overlap > max_overlap) max_overlap = overlap;
  end

  task automatic wait_enc_req(input int bound, input logic [15:0] addr, input logic we,
                              input logic [15:0] data, input bit chk_data);
    bit seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (bus.enc_request) seen = 1;
    end
    check("enc_request_rise", {31'd0, seen}, 1);
    check("enc_address", {16'd0, bus.enc_address}, {16'd0, addr});
    check("enc_write_enable", {31'd0, bus.enc_write_enable}, {31'd0, we});
    if (chk_data) check("enc_data_out", {16'd0, bus.enc_data_out}, {16'd0, data});
  endtask

  task automatic wait_ack(input bit port);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      if (port ? bus.b_ack : bus.a_ack) seen = 1;
    end
    check(port ? "b_ack_timeout" : "a_ack_timeout", {31'd0, seen}, 1);
    if (port) bus.b_req = 1'b0;
    else bus.a_req = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    int bad;
    int a_cnt;
    int b_cnt;
    int acks_before;
    bus.a_req = 1'b0; bus.a_address = '0; bus.a_write_enable = 1'b0; bus.a_data_out = '0;
    bus.b_req = 1'b0; bus.b_address = '0; bus.b_write_enable = 1'b0; bus.b_data_out = '0;
    bus.enc_initialized = 1'b0;

    // Uninitialised encoder: no grant even with a request pending.
    bus.a_req = 1'b1; bus.a_address = 16'h1234;
    do_reset();
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.enc_request || bus.a_ack || bus.b_ack || bus.enc_address != 0 ||
          bus.enc_write_enable || bus.enc_data_out != 0 || bus.a_data_in != 0 ||
          bus.b_data_in != 0) bad++;
    end
    check("uninit_outputs_idle", bad, 0);

    // Port A read
    exp_q.push_back({1'b0, 16'hBEEF});
    @(posedge clk); #1;
    bus.enc_initialized = 1'b1;
    wait_enc_req(2, 16'h1234, 1'b0, 16'h0, 1'b0);
    wait_ack(1'b0);
    check("b_data_in_untouched", {16'd0, bus.b_data_in}, 0);
    check("a_data_in_holds", {16'd0, bus.a_data_in}, {16'd0, 16'hBEEF});

    // Port B write
    exp_q.push_back({1'b1, 16'hA5A5});
    bus.b_address = 16'h00FF; bus.b_write_enable = 1'b1; bus.b_data_out = 16'hA5A5;
    bus.b_req = 1'b1;
    wait_enc_req(10, 16'h00FF, 1'b1, 16'hA5A5, 1'b1);
    wait_ack(1'b1);
    check("a_data_in_after_b", {16'd0, bus.a_data_in}, {16'd0, 16'hBEEF});

    // Both ports held after reset: A, B, A, B
    do_reset();
    exp_q.push_back({1'b0, 16'h1111});
    exp_q.push_back({1'b1, 16'h2222});
    exp_q.push_back({1'b0, 16'h3333});
    exp_q.push_back({1'b1, 16'h4444});
    bus.a_address = 16'h0010; bus.a_write_enable = 1'b1; bus.a_data_out = 16'h1111;
    bus.b_address = 16'h0020; bus.b_write_enable = 1'b1; bus.b_data_out = 16'h2222;
    bus.a_req = 1'b1; bus.b_req = 1'b1;
    a_cnt = 0; b_cnt = 0;
    for (int i = 0; i < 400 && (a_cnt < 2 || b_cnt < 2); i++) begin
      @(posedge clk); #1;
      if (bus.a_ack) begin
        a_cnt++;
        if (a_cnt == 1) bus.a_data_out = 16'h3333; else bus.a_req = 1'b0;
      end
      if (bus.b_ack) begin
        b_cnt++;
        if (b_cnt == 1) bus.b_data_out = 16'h4444; else bus.b_req = 1'b0;
      end
    end
    check("rr_a_acks", a_cnt, 2);
    check("rr_b_acks", b_cnt, 2);

    // Port A held for four back-to-back writes
    exp_q.push_back({1'b0, 16'h0001});
    exp_q.push_back({1'b0, 16'h0002});
    exp_q.push_back({1'b0, 16'h0003});
    exp_q.push_back({1'b0, 16'h0004});
    bus.a_data_out = 16'h0001; bus.a_req = 1'b1;
    a_cnt = 0;
    for (int i = 0; i < 400 && a_cnt < 4; i++) begin
      @(posedge clk); #1;
      if (bus.a_ack) begin
        a_cnt++;
        if (a_cnt < 4) bus.a_data_out = bus.a_data_out + 16'h1; else bus.a_req = 1'b0;
      end
    end
    check("b2b_a_acks", a_cnt, 4);
    check("req_busy_overlap_le1", {31'd0, max_overlap <= 1}, 1);

    // Reset while in WAIT during a port A read
    bus.a_write_enable = 1'b0; bus.a_address = 16'h0040; bus.a_req = 1'b1;
    bad = 1;
    for (int i = 0; i < 50 && bad != 0; i++) begin
      @(negedge clk);
      if (!bus.enc_request && bus.enc_busy) bad = 0;
    end
    check("reached_wait", bad, 0);
    acks_before = ack_total;
    @(posedge clk); #1;
    reset = 1'b1; bus.a_req = 1'b0;
    @(posedge clk); #1;
    check("rst_enc_request", {31'd0, bus.enc_request}, 0);
    check("rst_enc_address", {16'd0, bus.enc_address}, 0);
    check("rst_a_data_in", {16'd0, bus.a_data_in}, 0);
    check("rst_a_ack", {31'd0, bus.a_ack}, 0);
    reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("no_ack_after_abort", ack_total, acks_before);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
